// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder (DMEM_PARITY_EN widens RAM words)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_STORE   = 1'b1;
    localparam int   WAIT_CNT_W = 4;

`ifdef DMEM_PARITY_EN
    localparam int DMEM_W = 33;
`else
    localparam int DMEM_W = 32;
`endif

    // Even parity: the stored bit makes the XOR of all 33 bits zero.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with write enable and registered, enable-gated read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = DMEM_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only updates on loads so it holds the last loaded word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data-memory responder with wait states (DMEM_PARITY_EN adds PARERR)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TRANDATADDR,
    input  logic        SORL,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] MEMDATAI,
    output logic        MEMSTALL,
    output logic        ADDRERR
`ifdef DMEM_PARITY_EN
    ,
    output logic        PARERR
`endif
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0]     r_idx;
    logic [31:0]           r_data;
    logic                  r_op;

    logic                  w_req;
    logic                  w_to_done;
    logic                  w_op;
    logic [ADDR_W-1:0]     w_idx;
    logic [31:0]           w_wdata;
    logic [DMEM_W-1:0]     w_ram_wdata;
    logic [DMEM_W-1:0]     w_ram_rdata;
    logic                  w_unused;

    assign ADDRERR  = TRANDATADDR && (DADDR[1:0] != 2'b00);
    assign w_req    = TRANDATADDR && !ADDRERR;
    assign MEMSTALL = w_req && (r_state != DONE);
    assign w_unused = &{1'b0, DADDR[31:ADDR_W+2]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        w_state_nxt = DONE;
                        w_to_done   = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A dropped request means the pipeline flushed the access.
                if (!TRANDATADDR) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_to_done   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Zero-wait accesses reach DONE on the latching edge, so IDLE uses live inputs.
    assign w_op    = (r_state == IDLE) ? SORL : r_op;
    assign w_idx   = (r_state == IDLE) ? DADDR[ADDR_W+1:2] : r_idx;
    assign w_wdata = (r_state == IDLE) ? DATAO : r_data;

`ifdef DMEM_PARITY_EN
    assign w_ram_wdata = {even_parity(w_wdata), w_wdata};
    assign PARERR      = (r_state == DONE) && (r_op == OP_LOAD) && (^w_ram_rdata);
`else
    assign w_ram_wdata = w_wdata;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_op    <= OP_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && w_req) begin
                r_idx  <= DADDR[ADDR_W+1:2];
                r_data <= DATAO;
                r_op   <= SORL;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DMEM_W)
    ) u_array (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (reset && w_to_done && (w_op == OP_STORE)),
        .i_re    (reset && w_to_done && (w_op == OP_LOAD)),
        .i_addr  (w_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign MEMDATAI = w_ram_rdata[31:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (DMEM_PARITY_EN enables parity checks)
module tb_data_mem_responder;

    localparam int WC    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        TRANDATADDR;
    logic        SORL;
    logic [31:0] DADDR;
    logic [31:0] DATAO;
    logic [31:0] MEMDATAI;
    logic        MEMSTALL;
    logic        ADDRERR;
`ifdef DMEM_PARITY_EN
    logic        PARERR;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [int unsigned];
    bit          bad [int unsigned];
    int unsigned written [$];
    logic [31:0] exp_last;

    data_mem_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .TRANDATADDR (TRANDATADDR),
        .SORL        (SORL),
        .DADDR       (DADDR),
        .DATAO       (DATAO),
        .MEMDATAI    (MEMDATAI),
        .MEMSTALL    (MEMSTALL),
        .ADDRERR     (ADDRERR)
`ifdef DMEM_PARITY_EN
        ,
        .PARERR      (PARERR)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] addr);
        return (addr / 4) % DEPTH;
    endfunction

    // One complete access; inputs are scrambled during the stall to prove latching.
    task automatic access(input logic op, input logic [31:0] addr, input logic [31:0] data, input string tag);
        int n;
        int unsigned idx;
        idx = word_of(addr);
        @(negedge clk);
        TRANDATADDR = 1'b1;
        SORL        = op;
        DADDR       = addr;
        DATAO       = data;
        #1;
        n = 0;
        while (MEMSTALL === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            SORL  = 1'($urandom);
            DADDR = $urandom & 32'hFFFF_FFFC;
            DATAO = $urandom;
            #1;
        end
        check({tag, "_stall"}, 32'(n), 32'(WC + 1));
        if (op) begin
            mem[idx] = data;
            bad[idx] = 1'b0;
            written.push_back(idx);
        end else begin
            exp_last = mem.exists(idx) ? mem[idx] : 32'hx;
        end
        check({tag, "_data"}, MEMDATAI, exp_last);
`ifdef DMEM_PARITY_EN
        check({tag, "_par"}, 32'(PARERR), 32'(!op && bad.exists(idx) && bad[idx]));
`endif
        @(negedge clk);
        TRANDATADDR = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int unsigned k;

        reset = 1'b0;
        TRANDATADDR = 1'b0;
        SORL = 1'b0;
        DADDR = '0;
        DATAO = '0;
        exp_last = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_data", MEMDATAI, 32'h0);
        check("rst_stall", 32'(MEMSTALL), 32'h0);
        check("rst_aerr", 32'(ADDRERR), 32'h0);

        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "st10");
        access(1'b0, 32'h0000_0010, 32'h0, "ld10");

        // Misaligned load then store: flagged, no access, nothing changes.
        @(negedge clk);
        TRANDATADDR = 1'b1;
        SORL = 1'b0;
        DADDR = 32'h0000_0012;
        #1;
        check("mis_aerr", 32'(ADDRERR), 32'h1);
        check("mis_stall", 32'(MEMSTALL), 32'h0);
        @(negedge clk);
        SORL = 1'b1;
        DADDR = 32'h0000_0013;
        DATAO = 32'h0BAD_0BAD;
        #1;
        check("mis_aerr2", 32'(ADDRERR), 32'h1);
        check("mis_hold", MEMDATAI, exp_last);
        repeat (2) @(negedge clk);
        TRANDATADDR = 1'b0;
        #1;
        check("mis_clear", 32'(ADDRERR), 32'h0);
        access(1'b0, 32'h0000_0010, 32'h0, "ld10b");

        // Flush in the last wait cycle must not write.
        access(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, "st20");
        @(negedge clk);
        TRANDATADDR = 1'b1;
        SORL = 1'b1;
        DADDR = 32'h0000_0020;
        DATAO = 32'h1111_1111;
        repeat (2) @(negedge clk);
        TRANDATADDR = 1'b0;
        #1;
        check("abort_stall", 32'(MEMSTALL), 32'h0);
        access(1'b0, 32'h0000_0020, 32'h0, "ld20");

        access(1'b1, 32'h0000_1004, 32'h1234_5678, "st1004");
        access(1'b0, 32'h0000_0004, 32'h0, "alias4");

        // Reset in the middle of a store discards it.
        access(1'b1, 32'h0000_0040, 32'h4040_4040, "st40");
        @(negedge clk);
        TRANDATADDR = 1'b1;
        SORL = 1'b1;
        DADDR = 32'h0000_0040;
        DATAO = 32'h9999_9999;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_data", MEMDATAI, 32'h0);
        TRANDATADDR = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_last = '0;
        access(1'b0, 32'h0000_0040, 32'h0, "ld40");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                access(1'b1, $urandom & 32'hFFFF_FFFC, $urandom, "rnd_st");
            end else begin
                k = written[$urandom_range(written.size() - 1, 0)];
                a = ($urandom & 32'hFFFF_F000) | (k << 2);
                access(1'b0, a, 32'h0, "rnd_ld");
            end
        end

`ifdef DMEM_PARITY_EN
        access(1'b1, 32'h0000_0080, 32'h0F0F_0F0F, "pst80");
        access(1'b1, 32'h0000_0084, 32'h0000_0001, "pst84");
        @(negedge clk);
        dut.u_array.r_mem[32] = dut.u_array.r_mem[32] ^ 33'h1;
        mem[32] = mem[32] ^ 32'h1;
        bad[32] = 1'b1;
        access(1'b0, 32'h0000_0080, 32'h0, "pld80");
        access(1'b0, 32'h0000_0084, 32'h0, "pld84");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts the word request driven by the MEM stage (TRANDATADDR, SORL, DADDR, DATAO) and services it from an internal word-addressed RAM after a programmable number of wait states.
- Returns read data on MEMDATAI, stalls the pipeline with MEMSTALL until the access completes, and flags misaligned addresses on ADDRERR.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W words.
- WAIT_CYCLES, 1, extra wait states per access; legal range 0..15.

Ports:
- clk  input  1  clock; the block is posedge-triggered.
- reset  input  1  reset, asynchronous, active-low.
- TRANDATADDR  input  1  request valid: a load or store is present this cycle.
- SORL  input  1  1 = store (write), 0 = load (read).
- DADDR  input  32  byte address.
- DATAO  input  32  store data from the CPU.
- MEMDATAI  output  32  load data to the MEM stage.
- MEMSTALL  output  1  high while the request is not yet complete.
- ADDRERR  output  1  misaligned-address indication.

Behaviour:
- States: IDLE, WAIT, DONE. A 4-bit wait counter cnt.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, MEMDATAI=0, latched address/data/op cleared.
  - RAM contents are not cleared.
- ADDRERR (combinational):
  - ADDRERR = TRANDATADDR && DADDR[1:0]!=0.
  - While ADDRERR is high: no access, MEMSTALL=0, state remains IDLE.
- MEMSTALL (combinational):
  - MEMSTALL = TRANDATADDR && !ADDRERR && state!=DONE.
- IDLE:
  - On an aligned request, latch the word index DADDR[ADDR_W+1:2], DATAO and SORL.
  - Next state: WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise DONE.
- WAIT:
  - If TRANDATADDR=0 (pipeline flush): abort to IDLE, no RAM write.
  - Else if cnt==0: go to DONE. Otherwise cnt decrements.
- Transition into DONE:
  - Store: write the latched data to the latched index.
  - Load: MEMDATAI <= RAM[latched index].
- DONE:
  - Lasts exactly one cycle; MEMSTALL=0 so the pipeline advances.
  - Then unconditionally returns to IDLE. A request seen in that next cycle is treated as a new access.
- Latency and ordering:
  - Total latency = WAIT_CYCLES+1 posedges; MEMSTALL is high for WAIT_CYCLES+1 cycles.
  - Latched values are used throughout the access. Changes to DADDR, DATAO or SORL during WAIT are ignored.
  - MEMDATAI holds its last loaded value until the next load completes; stores do not alter it.
- Address range: address bits above ADDR_W+1 are ignored, so addresses alias modulo the RAM size.
- Reset mid-access: the access is discarded and no write occurs unless the transition into DONE has already taken place.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- With DMEM_PARITY_EN defined:
  - Each RAM word stores one extra even-parity bit, computed on write.
  - On a load, a parity mismatch pulses output PARERR (1 bit, added port) high during the DONE cycle. Data is still returned.
  - PARERR resets to 0.
- Without it: no parity bit and no PARERR port; RAM width is 32.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE, WAIT, DONE);
  - op constants OP_LOAD=0, OP_STORE=1;
  - WAIT_CNT_W=4.
- Sub-module dmem_array: single-port synchronous RAM with write enable and registered read, width 32 or 33 depending on DMEM_PARITY_EN.

Test Plan:
- Reset released, no request → MEMDATAI=0, MEMSTALL=0, ADDRERR=0, state IDLE.
- WAIT_CYCLES=1: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → MEMSTALL high 2 cycles for each access; the load's DONE cycle shows MEMDATAI=0xDEADBEEF.
- Load from 0x0000_0012 → ADDRERR=1 the same cycle, MEMSTALL=0, RAM unchanged, MEMDATAI unchanged.
- WAIT_CYCLES=3: store to 0x20 with TRANDATADDR dropped after 2 cycles → abort to IDLE; a later load of 0x20 returns the prior contents.
- ADDR_W=10: store 0x12345678 to 0x0000_1004 → a load from 0x0000_0004 returns 0x12345678 (aliasing).
- DMEM_PARITY_EN defined: force a bit flip in a stored word via the bench → load pulses PARERR=1 for one cycle in DONE; an unflipped word gives PARERR=0.
